pll_dri_reconfig_ctrl: RTL and testbench

Sequencer for the PolarFire CCC/PLL dynamic reconfiguration interface (DRI). Accepts a new OUT0 divider value over a valid/ready handshake and performs a read-modify-write of the PLL divider register. It holds the downstream fabric in reset while the PLL relocks, then releases it after a lock-stable interval. While idle it also supervises PLL lock and holds fabric reset during any loss of lock.

---
 rtl/pll_dri_pkg.sv | 39 +++
 rtl/pll_lock_sync.sv | 21 ++
 rtl/pll_dri_reconfig_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pll_dri_reconfig_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_dri_pkg.sv
// Shared types and DRI field layout for the PLL divider reconfiguration sequencer.
package pll_dri_pkg;

    localparam int STB_BIT    = 10;
    localparam int WR_BIT     = 9;
    localparam int ADDR_W     = 9;
    localparam int CTRL_W     = STB_BIT + 1;
    localparam int DRI_DATA_W = 33;
    localparam int DIV_W      = 7;

    typedef enum logic [2:0] {
        IDLE,
        RST_ASSERT,
        RD,
        WR,
        BLANK,
        LOCK_WAIT,
        SETTLE
    } state_t;

    function automatic logic [CTRL_W-1:0] dri_cmd(input logic wr, input logic [ADDR_W-1:0] addr);
        logic [CTRL_W-1:0] cmd;
        cmd             = '0;
        cmd[STB_BIT]    = 1'b1;
        cmd[WR_BIT]     = wr;
        cmd[ADDR_W-1:0] = addr;
        return cmd;
    endfunction

    // Replace the 7-bit divider field at bit lsb, preserving every other register bit.
    function automatic logic [DRI_DATA_W-1:0] merge_div(input logic [DRI_DATA_W-1:0] data,
                                                        input logic [DIV_W-1:0]      div,
                                                        input int                    lsb);
        logic [DRI_DATA_W-1:0] mask;
        mask = DRI_DATA_W'({DIV_W{1'b1}}) << lsb;
        return (data & ~mask) | ((DRI_DATA_W'(div) << lsb) & mask);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the DRI clock domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pll_dri_reconfig_ctrl.sv
// Read-modify-write of the PLL OUT0 divider over DRI, with fabric reset held until the
// PLL has relocked and stayed locked; in IDLE it keeps supervising lock.
module pll_dri_reconfig_ctrl
    import pll_dri_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DIV_REG_ADDR      = 9'h004,
    parameter int                DIV_LSB           = 0,
    parameter int                DRI_ACCESS_CYCLES = 4,
    parameter int                LOCK_BLANK_CYCLES = 1024,
    parameter int                LOCK_TIMEOUT      = 65535,
    parameter int                SETTLE_CYCLES     = 256
) (
    input  logic                  DRI_CLK,
    input  logic                  DRI_ARST_N,
    input  logic                  PLL_LOCK_0,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [DIV_W-1:0]      REQ_DIV,
    output logic [CTRL_W-1:0]     DRI_CTRL,
    output logic [DRI_DATA_W-1:0] DRI_WDATA,
    input  logic [DRI_DATA_W-1:0] DRI_RDATA,
    output logic                  FABRIC_RST_N,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  LOCKED
);

    localparam int ACC_W = $clog2(DRI_ACCESS_CYCLES + 1);
    localparam int BLK_W = $clog2(LOCK_BLANK_CYCLES + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(DRI_ACCESS_CYCLES);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(LOCK_BLANK_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SETTLE_CYCLES);

    if (DRI_ACCESS_CYCLES < 1 || LOCK_BLANK_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
        SETTLE_CYCLES < 1 || DIV_LSB < 0 || DIV_LSB + DIV_W > DRI_DATA_W) begin : g_bad_param
        $error("pll_dri_reconfig_ctrl: illegal parameter combination");
    end

    state_t           state;
    logic             lock_s;
    logic [DIV_W-1:0] div_q;
    logic [ACC_W-1:0] acc_cnt;
    logic [BLK_W-1:0] blk_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [SET_W-1:0] set_cnt;

    pll_lock_sync u_lock_sync (
        .clk      (DRI_CLK),
        .rst_n    (DRI_ARST_N),
        .async_in (PLL_LOCK_0),
        .sync_out (lock_s)
    );

    assign LOCKED = lock_s;

    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            state        <= IDLE;
            div_q        <= '0;
            acc_cnt      <= '0;
            blk_cnt      <= '0;
            to_cnt       <= '0;
            set_cnt      <= '0;
            DRI_CTRL     <= '0;
            DRI_WDATA    <= '0;
            FABRIC_RST_N <= 1'b0;
            REQ_READY    <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            unique case (state)
                IDLE: begin
                    REQ_READY <= 1'b1;
                    BUSY      <= 1'b0;
                    // Lock supervision: any low sample restarts the stability interval.
                    if (!lock_s) begin
                        set_cnt      <= '0;
                        FABRIC_RST_N <= 1'b0;
                    end else begin
                        if (set_cnt != SET_MAX) set_cnt <= set_cnt + 1'b1;
                        if (set_cnt >= SET_LAST) FABRIC_RST_N <= 1'b1;
                    end
                    if (REQ_VALID && REQ_READY) begin
                        if (REQ_DIV == '0) begin
                            DONE <= 1'b1;
                            ERR  <= 1'b1;
                        end else begin
                            div_q        <= REQ_DIV;
                            state        <= RST_ASSERT;
                            REQ_READY    <= 1'b0;
                            BUSY         <= 1'b1;
                            FABRIC_RST_N <= 1'b0;
                        end
                    end
                end
                RST_ASSERT: begin
                    state    <= RD;
                    DRI_CTRL <= dri_cmd(1'b0, DIV_REG_ADDR);
                    acc_cnt  <= ACC_W'(1);
                end
                RD: begin
                    if (acc_cnt == ACC_LAST) begin
                        state     <= WR;
                        DRI_CTRL  <= dri_cmd(1'b1, DIV_REG_ADDR);
                        DRI_WDATA <= merge_div(DRI_RDATA, div_q, DIV_LSB);
                        acc_cnt   <= ACC_W'(1);
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                end
                WR: begin
                    if (acc_cnt == ACC_LAST) begin
                        state    <= BLANK;
                        DRI_CTRL <= '0;
                        blk_cnt  <= BLK_W'(1);
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (blk_cnt == BLK_LAST) begin
                        state  <= LOCK_WAIT;
                        to_cnt <= TO_W'(1);
                    end else begin
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                end
                // to_cnt holds the number of LOCK_WAIT cycles spent so far, including this one.
                LOCK_WAIT: begin
                    if (lock_s) begin
                        state   <= SETTLE;
                        set_cnt <= '0;
                    end else if (to_cnt >= TO_LAST) begin
                        state        <= IDLE;
                        DONE         <= 1'b1;
                        ERR          <= 1'b1;
                        REQ_READY    <= 1'b1;
                        BUSY         <= 1'b0;
                        FABRIC_RST_N <= 1'b0;
                        set_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state <= LOCK_WAIT;
                        if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
                    end else if (set_cnt == SET_LAST) begin
                        state        <= IDLE;
                        DONE         <= 1'b1;
                        FABRIC_RST_N <= 1'b1;
                        REQ_READY    <= 1'b1;
                        BUSY         <= 1'b0;
                        set_cnt      <= SET_MAX;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_dri_reconfig_ctrl.sv
// Scoreboard bench: expected DRI accesses and DONE responses are queued by the stimulus,
// independent monitors pop and compare them as the DUT produces them.
module tb_pll_dri_reconfig_ctrl;
    import pll_dri_pkg::*;

    localparam int DAC = 4;
    localparam int LBC = 100;
    localparam int TMO = 1000;
    localparam int SC  = 40;
    localparam logic [10:0] CTRL_RD = 11'h404;
    localparam logic [10:0] CTRL_WR = 11'h604;

    logic        DRI_CLK    = 1'b0;
    logic        DRI_ARST_N = 1'b0;
    logic        PLL_LOCK_0 = 1'b1;
    logic        REQ_VALID  = 1'b0;
    logic [6:0]  REQ_DIV    = '0;
    logic [32:0] DRI_RDATA  = '0;
    logic        REQ_READY, FABRIC_RST_N, BUSY, DONE, ERR, LOCKED;
    logic [10:0] DRI_CTRL;
    logic [32:0] DRI_WDATA;

    pll_dri_reconfig_ctrl #(
        .DIV_REG_ADDR      (9'h004),
        .DIV_LSB           (0),
        .DRI_ACCESS_CYCLES (DAC),
        .LOCK_BLANK_CYCLES (LBC),
        .LOCK_TIMEOUT      (TMO),
        .SETTLE_CYCLES     (SC)
    ) dut (
        .DRI_CLK      (DRI_CLK),
        .DRI_ARST_N   (DRI_ARST_N),
        .PLL_LOCK_0   (PLL_LOCK_0),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_DIV      (REQ_DIV),
        .DRI_CTRL     (DRI_CTRL),
        .DRI_WDATA    (DRI_WDATA),
        .DRI_RDATA    (DRI_RDATA),
        .FABRIC_RST_N (FABRIC_RST_N),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ERR          (ERR),
        .LOCKED       (LOCKED)
    );

    always #5 DRI_CLK = ~DRI_CLK;

    typedef struct { logic err; logic frst; int cyc; } done_exp_t;
    typedef struct { logic [10:0] ctrl; logic [32:0] wdata; logic chk_wdata; int len; } acc_exp_t;

    done_exp_t done_q[$];
    acc_exp_t  acc_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge DRI_CLK);
        cyc++;
    end

    // DONE monitor
    done_exp_t mde;
    initial forever begin
        @(negedge DRI_CLK);
        if (DONE === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected actual=DONE expected=no DONE (cycle %0d)", cyc);
            end else begin
                mde = done_q.pop_front();
                check("done_err",   64'(ERR),          64'(mde.err));
                check("done_frst",  64'(FABRIC_RST_N), 64'(mde.frst));
                check("done_cycle", 64'(cyc),          64'(mde.cyc));
            end
        end
    end

    // DRI bus monitor: collapses each strobe run into one access record
    logic        run_on = 1'b0;
    logic [10:0] run_ctrl = '0;
    logic [32:0] run_wdata = '0;
    int          run_len = 0;
    acc_exp_t    mae;
    initial forever begin
        @(negedge DRI_CLK);
        if (run_on && DRI_CTRL === run_ctrl) begin
            run_len++;
        end else begin
            if (run_on) begin
                if (acc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dri_unexpected actual=ctrl %h len %0d expected=no access", run_ctrl, run_len);
                end else begin
                    mae = acc_q.pop_front();
                    check("dri_ctrl", 64'(run_ctrl), 64'(mae.ctrl));
                    check("dri_len",  64'(run_len),  64'(mae.len));
                    if (mae.chk_wdata) check("dri_wdata", 64'(run_wdata), 64'(mae.wdata));
                end
            end
            run_on    = (DRI_CTRL[10] === 1'b1);
            run_ctrl  = DRI_CTRL;
            run_wdata = DRI_WDATA;
            run_len   = 1;
        end
    end

    task automatic push_rmw(input logic [32:0] wdata, input int wr_len);
        acc_q.push_back(acc_exp_t'{CTRL_RD, 33'h0, 1'b0, DAC});
        acc_q.push_back(acc_exp_t'{CTRL_WR, wdata, 1'b1, wr_len});
    endtask

    // Holds REQ_VALID until READY; the expected DONE is queued before the accepting edge.
    task automatic do_req(input logic [6:0] div, input bit push, input logic e_err,
                          input logic e_frst, input int lat, output int acc_cyc);
        @(negedge DRI_CLK);
        REQ_VALID = 1'b1;
        REQ_DIV   = div;
        for (int i = 0; i < 100 && REQ_READY !== 1'b1; i++) @(negedge DRI_CLK);
        check("req_ready", 64'(REQ_READY), 64'(1'b1));
        acc_cyc = cyc + 1;
        if (push) done_q.push_back(done_exp_t'{e_err, e_frst, acc_cyc + lat});
        @(negedge DRI_CLK);
        REQ_VALID = 1'b0;
        REQ_DIV   = '0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_q.size() != 0; i++) @(negedge DRI_CLK);
        check("done_q_drained", 64'(done_q.size()), 64'(0));
        done_q.delete();
        @(negedge DRI_CLK);
        check("dri_q_drained", 64'(acc_q.size()), 64'(0));
        acc_q.delete();
    endtask

    // Call at the negedge where lock (or reset release) has just become effective.
    task automatic check_release(input string tag);
        repeat (SC + 1) @(negedge DRI_CLK);
        check({tag, "_rst_held"}, 64'(FABRIC_RST_N), 64'(1'b0));
        @(negedge DRI_CLK);
        check({tag, "_rst_release"}, 64'(FABRIC_RST_N), 64'(1'b1));
    endtask

    initial begin
        #(20000 * 10);
        failures++;
        $display("FAIL watchdog actual=still running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge DRI_CLK);
        check("rst_ctrl",  64'(DRI_CTRL),  64'(0));
        check("rst_wdata", 64'(DRI_WDATA), 64'(0));
        check("rst_outs",  64'({FABRIC_RST_N, DONE, ERR, BUSY, REQ_READY, LOCKED}), 64'(0));

        // Reset release with lock already high
        DRI_ARST_N = 1'b1;
        @(negedge DRI_CLK);
        check("ready_first_edge", 64'(REQ_READY), 64'(1'b1));
        check("idle_ctrl",        64'(DRI_CTRL),  64'(0));
        check("locked_1cyc",      64'(LOCKED),    64'(1'b0));
        @(negedge DRI_CLK);
        check("locked_2cyc",      64'(LOCKED),    64'(1'b1));
        repeat (SC - 1) @(negedge DRI_CLK);
        check("init_rst_held",    64'(FABRIC_RST_N), 64'(1'b0));
        @(negedge DRI_CLK);
        check("init_rst_release", 64'(FABRIC_RST_N), 64'(1'b1));

        // Divider 25, PLL drops lock for 500 cycles
        DRI_RDATA = 33'h1_FFFF_FF80;
        push_rmw(33'h1_FFFF_FF99, DAC);
        do_req(7'd25, 1'b1, 1'b0, 1'b1, 503 + SC, acc);
        PLL_LOCK_0 = 1'b0;
        repeat (500) @(negedge DRI_CLK);
        PLL_LOCK_0 = 1'b1;
        wait_done(SC + 200);

        // Illegal divider
        do_req(7'd0, 1'b1, 1'b1, 1'b1, 0, acc);
        wait_done(20);
        check("div0_busy", 64'(BUSY), 64'(1'b0));

        // Lock never returns: timeout, then the monitor releases on later lock
        push_rmw(33'h1_FFFF_FF8A, DAC);
        do_req(7'd10, 1'b1, 1'b1, 1'b0, 1 + 2 * DAC + LBC + TMO, acc);
        PLL_LOCK_0 = 1'b0;
        wait_done(TMO + LBC + 100);
        repeat (5) @(negedge DRI_CLK);
        check("timeout_rst_low", 64'(FABRIC_RST_N), 64'(1'b0));
        PLL_LOCK_0 = 1'b1;
        check_release("relock");

        // Three-cycle lock glitch in the middle of SETTLE
        push_rmw(33'h1_FFFF_FFE4, DAC);
        do_req(7'd100, 1'b1, 1'b0, 1'b1, 136 + SC, acc);
        repeat (130) @(negedge DRI_CLK);
        PLL_LOCK_0 = 1'b0;
        repeat (3) @(negedge DRI_CLK);
        PLL_LOCK_0 = 1'b1;
        wait_done(SC + 200);

        // Reset asserted during the write strobe
        push_rmw(33'h1_FFFF_FF87, 2);
        do_req(7'd7, 1'b0, 1'b0, 1'b0, 0, acc);
        repeat (6) @(negedge DRI_CLK);
        check("wr_strobe_before_rst", 64'(DRI_CTRL), 64'(CTRL_WR));
        #2 DRI_ARST_N = 1'b0;
        #1;
        check("async_ctrl_drop", 64'(DRI_CTRL), 64'(0));
        check("async_outs", 64'({FABRIC_RST_N, DONE, ERR, BUSY, REQ_READY}), 64'(0));
        check("async_wdata", 64'(DRI_WDATA), 64'(0));
        repeat (3) @(negedge DRI_CLK);
        DRI_ARST_N = 1'b1;
        check_release("rearm");
        check("abort_dri_q", 64'(acc_q.size()), 64'(0));

        // Fresh request after the aborted one
        DRI_RDATA = 33'h0_A5A5_A5FF;
        push_rmw(33'h0_A5A5_A5B2, DAC);
        do_req(7'd50, 1'b1, 1'b0, 1'b1, 1 + 2 * DAC + LBC + 1 + SC, acc);
        wait_done(LBC + SC + 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
